// File: rtl/aurora_sup_pkg.sv
// aurora_sup_pkg: shared state encodings, widths and default timing constants
// for the Aurora link supervisor.
package aurora_sup_pkg;

    // Supervisor states; the numeric values are exported unchanged on state_dbg.
    typedef enum logic [2:0] {
        ST_RST     = 3'd0,
        ST_PB_HOLD = 3'd1,
        ST_WAIT_UP = 3'd2,
        ST_UP      = 3'd3,
        ST_DOWN    = 3'd4
    } sup_state_t;

    localparam int STATE_W = 3;
    localparam int RETRY_W = 8;
    localparam int DROP_W  = 16;

    // Default timing for the 2-lane QSFP channel.
    localparam int DEF_NUM_LANES      = 2;
    localparam int DEF_PMA_HOLD_CYC   = 128;
    localparam int DEF_PB_HOLD_CYC    = 64;
    localparam int DEF_DEBOUNCE_CYC   = 16;
    localparam int DEF_UP_TIMEOUT_CYC = 1048576;

    // Largest of three limits; sizes the phase counter shared by RST,
    // PB_HOLD and the WAIT_UP timeout.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/aurora_sup_sync.sv
// aurora_sup_sync: parameterized-width 2-flop synchronizer for level signals
// entering the ap_clk domain. Bits are synchronized independently, so the
// consumer must not assume coherence between bits of the vector.
module aurora_sup_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; second stage gives it a full cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            // NOTE: non-blocking so q takes the old meta; a blocking pair would collapse into one flop.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/aurora_link_supervisor.sv
// aurora_link_supervisor: bring-up and recovery sequencer for a bonded Aurora
// channel. Walks pma_init / reset_pb through their release order, debounces
// channel_up, and restarts the sequence on timeout, channel drop or a
// software force_reinit.
//
// Optional build macro AURORA_SUP_STATS_EN adds drop_cnt and last_lane_up
// diagnostic outputs; without it those ports and their logic do not exist.
module aurora_link_supervisor
    import aurora_sup_pkg::*;
#(
    parameter int NUM_LANES      = DEF_NUM_LANES,
    parameter int PMA_HOLD_CYC   = DEF_PMA_HOLD_CYC,
    parameter int PB_HOLD_CYC    = DEF_PB_HOLD_CYC,
    parameter int DEBOUNCE_CYC   = DEF_DEBOUNCE_CYC,
    parameter int UP_TIMEOUT_CYC = DEF_UP_TIMEOUT_CYC
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 channel_up,
    input  logic [NUM_LANES-1:0] lane_up,
    input  logic                 force_reinit,
    output logic                 pma_init,
    output logic                 reset_pb,
    output logic                 link_ok,
    output logic [NUM_LANES-1:0] lane_up_sync,
    output logic [RETRY_W-1:0]   retry_cnt,
`ifdef AURORA_SUP_STATS_EN
    output logic [DROP_W-1:0]    drop_cnt,
    output logic [NUM_LANES-1:0] last_lane_up,
`endif
    output logic [STATE_W-1:0]   state_dbg
);

    // ------------------------------------------------------------------
    // Counter sizing
    // ------------------------------------------------------------------
    localparam int PHASE_MAX = max3(PMA_HOLD_CYC, PB_HOLD_CYC, UP_TIMEOUT_CYC);
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int DEB_W     = $clog2(DEBOUNCE_CYC + 1);

    // RST and PB_HOLD last exactly their hold counts, so they leave on the
    // final count value rather than on the limit itself.
    localparam logic [PHASE_W-1:0] PMA_LAST    = PHASE_W'(PMA_HOLD_CYC - 1);
    localparam logic [PHASE_W-1:0] PB_LAST     = PHASE_W'(PB_HOLD_CYC - 1);
    localparam logic [PHASE_W-1:0] TIMEOUT_LIM = PHASE_W'(UP_TIMEOUT_CYC);
    localparam logic [DEB_W-1:0]   DEB_LIM     = DEB_W'(DEBOUNCE_CYC);

    // ------------------------------------------------------------------
    // Reset bridge
    // ------------------------------------------------------------------
    logic [1:0] rst_pipe;
    logic       rst_sync_n;

    // Assert asynchronously, release two ap_clk edges after ap_rst_n rises.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    // Flop-driven so the release is glitch-free; the assert still follows
    // ap_rst_n immediately because rst_pipe clears asynchronously.
    assign rst_sync_n = rst_pipe[1];

    // ------------------------------------------------------------------
    // Input synchronization (lane_up and channel_up come from user_clk)
    // ------------------------------------------------------------------
    logic [NUM_LANES:0] link_raw;
    logic [NUM_LANES:0] link_sync;
    logic               chan_up_s;

    assign link_raw = {lane_up, channel_up};

    aurora_sup_sync #(
        .WIDTH (NUM_LANES + 1)
    ) u_sync (
        .clk   (ap_clk),
        .rst_n (rst_sync_n),
        .d     (link_raw),
        .q     (link_sync)
    );

    assign chan_up_s    = link_sync[0];
    assign lane_up_sync = link_sync[NUM_LANES:1];

    // ------------------------------------------------------------------
    // FSM state and counters
    // ------------------------------------------------------------------
    sup_state_t         state;
    logic [PHASE_W-1:0] phase_cnt;
    logic [DEB_W-1:0]   deb_cnt;

    assign state_dbg = state;

    // Shared decode, also used by the optional statistics block.
    logic               up_drop;
    logic               deb_done;
    logic               timeout_fire;
    logic [RETRY_W-1:0] retry_next;

    assign up_drop      = (state == ST_UP) && !chan_up_s;
    assign deb_done     = (deb_cnt == DEB_LIM);
    // Debounce completion wins over a coincident timeout; force_reinit wins over both.
    assign timeout_fire = (state == ST_WAIT_UP) && !force_reinit && !deb_done &&
                          (phase_cnt == TIMEOUT_LIM);
    assign retry_next   = (retry_cnt == '1) ? retry_cnt : retry_cnt + 1'b1;

    // Sequencer: state, phase/debounce counters and all registered outputs.
    always_ff @(posedge ap_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state     <= ST_RST;
            phase_cnt <= '0;
            deb_cnt   <= '0;
            pma_init  <= 1'b1;
            reset_pb  <= 1'b1;
            link_ok   <= 1'b0;
            retry_cnt <= '0;
        end else if (force_reinit) begin
            // Software restart overrides every other transition.
            state     <= ST_RST;
            phase_cnt <= '0;
            deb_cnt   <= '0;
            pma_init  <= 1'b1;
            reset_pb  <= 1'b1;
            link_ok   <= 1'b0;
            retry_cnt <= retry_next;
        end else begin
            case (state)
                ST_RST: begin
                    if (phase_cnt == PMA_LAST) begin
                        state     <= ST_PB_HOLD;
                        phase_cnt <= '0;
                        pma_init  <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                ST_PB_HOLD: begin
                    if (phase_cnt == PB_LAST) begin
                        state     <= ST_WAIT_UP;
                        phase_cnt <= '0;
                        deb_cnt   <= '0;
                        reset_pb  <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                ST_WAIT_UP: begin
                    if (deb_done) begin
                        state     <= ST_UP;
                        phase_cnt <= '0;
                        deb_cnt   <= '0;
                        link_ok   <= 1'b1;
                    end else if (timeout_fire) begin
                        state     <= ST_RST;
                        phase_cnt <= '0;
                        deb_cnt   <= '0;
                        pma_init  <= 1'b1;
                        reset_pb  <= 1'b1;
                        retry_cnt <= retry_next;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                        // Any synced low restarts the run of consecutive highs.
                        deb_cnt   <= chan_up_s ? deb_cnt + 1'b1 : '0;
                    end
                end

                ST_UP: begin
                    if (up_drop) begin
                        state     <= ST_DOWN;
                        phase_cnt <= '0;
                        link_ok   <= 1'b0;
                    end
                end

                ST_DOWN: begin
                    // A drop is not a retry; just restart the sequence.
                    state     <= ST_RST;
                    phase_cnt <= '0;
                    deb_cnt   <= '0;
                    pma_init  <= 1'b1;
                    reset_pb  <= 1'b1;
                end

                default: begin
                    state     <= ST_RST;
                    phase_cnt <= '0;
                    deb_cnt   <= '0;
                    pma_init  <= 1'b1;
                    reset_pb  <= 1'b1;
                    link_ok   <= 1'b0;
                end
            endcase
        end
    end

`ifdef AURORA_SUP_STATS_EN
    // Diagnostics: count UP->DOWN drops (even under force_reinit) and
    // snapshot the lane status whenever a WAIT_UP timeout fires.
    always_ff @(posedge ap_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            drop_cnt     <= '0;
            last_lane_up <= '0;
        end else begin
            if (up_drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (timeout_fire) begin
                last_lane_up <= lane_up_sync;
            end
        end
    end
`endif

endmodule
